// File: rtl/cache_evict_fill_if.sv
// Per-beat bus handshake between the miss sequencer (master) and the memory bus (slave).
interface cache_evict_fill_if #(
  parameter int PALEN = 34
);
  logic             BusRead;
  logic             BusWrite;
  logic [PALEN-1:0] BusAdr;
  logic             BusBeatAck;

  modport master (
    output BusRead,
    output BusWrite,
    output BusAdr,
    input  BusBeatAck
  );

  modport slave (
    input  BusRead,
    input  BusWrite,
    input  BusAdr,
    output BusBeatAck
  );
endinterface

// File: rtl/cache_evict_fill.sv
// Cache miss sequencer: captures the victim way, writes back a dirty victim, fills the line.
// Optional eviction/writeback counters and the VictimValid port exist under CACHE_EVICT_PERF_EN.
module cache_evict_fill #(
  parameter int NUMWAYS      = 4,
  parameter int SETLEN       = 9,
  parameter int OFFSETLEN    = 5,
  parameter int TAGLEN       = 20,
  parameter int BEATSPERLINE = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 FlushStage,
  input  logic                                 Miss,
  input  logic [TAGLEN+SETLEN+OFFSETLEN-1:0]   PAdr,
  input  logic [NUMWAYS-1:0]                   VictimWay,
  input  logic                                 VictimDirty,
  input  logic [TAGLEN-1:0]                    VictimTag,
`ifdef CACHE_EVICT_PERF_EN
  input  logic                                 VictimValid,
`endif
  cache_evict_fill_if.master                   bus,
  output logic                                 CacheStall,
  output logic [$clog2(BEATSPERLINE)-1:0]      BeatCount,
  output logic [NUMWAYS-1:0]                   SelWay,
  output logic                                 LineWriteEn,
  output logic                                 SetValid,
  output logic                                 ClearDirty,
  output logic                                 LRUWriteEn,
  output logic [31:0]                          EvictCount,
  output logic [31:0]                          WritebackCount
);

  localparam int BEATLEN = $clog2(BEATSPERLINE);
  localparam int PALEN   = TAGLEN + SETLEN + OFFSETLEN;
  localparam logic [BEATLEN-1:0] LAST_BEAT = BEATLEN'(BEATSPERLINE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NUMWAYS-1:0]  sel_way_q, sel_way_d;
  logic [SETLEN-1:0]   set_q, set_d;
  logic [TAGLEN-1:0]   tag_q, tag_d;
  logic [TAGLEN-1:0]   victim_tag_q, victim_tag_d;
  logic [BEATLEN-1:0]  beat_q, beat_d;

  logic                accept;
  logic                bus_read;
  logic                bus_write;
  logic [PALEN-1:0]    bus_adr;
  logic [TAGLEN-1:0]   adr_tag;

  // Byte offset of the missing access is irrelevant: whole lines move.
  logic unused_offset;
  assign unused_offset = ^PAdr[OFFSETLEN-1:0];

  assign accept = (state_q == IDLE) && Miss && !FlushStage;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    sel_way_d    = sel_way_q;
    set_d        = set_q;
    tag_d        = tag_q;
    victim_tag_d = victim_tag_q;
    beat_d       = beat_q;
    CacheStall   = 1'b0;
    bus_read     = 1'b0;
    bus_write    = 1'b0;
    bus_adr      = '0;
    adr_tag      = tag_q;
    LineWriteEn  = 1'b0;
    SetValid     = 1'b0;
    ClearDirty   = 1'b0;
    LRUWriteEn   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Capture in the first Miss cycle, while the replacement block still presents this victim.
        if (accept) begin
          CacheStall   = 1'b1;
          sel_way_d    = VictimWay;
          set_d        = PAdr[OFFSETLEN +: SETLEN];
          tag_d        = PAdr[PALEN-1 -: TAGLEN];
          victim_tag_d = VictimTag;
          beat_d       = '0;
          state_d      = VictimDirty ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        CacheStall = 1'b1;
        bus_write  = 1'b1;
        adr_tag    = victim_tag_q;
        if (bus.BusBeatAck) begin
          beat_d = beat_q + BEATLEN'(1);
          if (beat_q == LAST_BEAT) state_d = FILL;
        end
      end

      FILL: begin
        CacheStall  = 1'b1;
        bus_read    = 1'b1;
        LineWriteEn = bus.BusBeatAck;
        if (bus.BusBeatAck) begin
          beat_d = beat_q + BEATLEN'(1);
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end

      DONE: begin
        SetValid   = 1'b1;
        ClearDirty = 1'b1;
        LRUWriteEn = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (bus_read || bus_write) begin
      bus_adr = (PALEN'({adr_tag, set_q}) << OFFSETLEN)
              | (PALEN'(beat_q) << (OFFSETLEN - BEATLEN));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_way_q    <= '0;
      set_q        <= '0;
      tag_q        <= '0;
      victim_tag_q <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      sel_way_q    <= sel_way_d;
      set_q        <= set_d;
      tag_q        <= tag_d;
      victim_tag_q <= victim_tag_d;
      beat_q       <= beat_d;
    end
  end

  assign bus.BusRead  = bus_read;
  assign bus.BusWrite = bus_write;
  assign bus.BusAdr   = bus_adr;
  assign BeatCount    = beat_q;
  assign SelWay       = sel_way_q;

`ifdef CACHE_EVICT_PERF_EN
  logic        victim_valid_q, victim_valid_d;
  logic [31:0] evict_count_q, evict_count_d;
  logic [31:0] wb_count_q, wb_count_d;

  always_comb begin
    victim_valid_d = victim_valid_q;
    evict_count_d  = evict_count_q;
    wb_count_d     = wb_count_q;
    if (accept) begin
      victim_valid_d = VictimValid;
      if (VictimDirty) wb_count_d = wb_count_q + 32'd1;
    end
    if ((state_q == DONE) && victim_valid_q) evict_count_d = evict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      victim_valid_q <= 1'b0;
      evict_count_q  <= '0;
      wb_count_q     <= '0;
    end else begin
      victim_valid_q <= victim_valid_d;
      evict_count_q  <= evict_count_d;
      wb_count_q     <= wb_count_d;
    end
  end

  assign EvictCount     = evict_count_q;
  assign WritebackCount = wb_count_q;
`else
  assign EvictCount     = '0;
  assign WritebackCount = '0;
`endif

endmodule
